// File: rtl/reset_request.sv
// Merges the reset button, keyboard reset pulse and OSD reset level into one
// clean active-low request with a minimum pulse width and a post-release holdoff.
module reset_request #(
    parameter int DB_COUNT  = 200,
    parameter int MIN_PULSE = 64,
    parameter int HOLDOFF   = 255
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_n,
    input  logic       key_req,
    input  logic       osd_req,
    output logic       req_rst_n,
    output logic       busy,
    output logic [1:0] cause
);

    localparam int CNT_MAX = (MIN_PULSE > HOLDOFF) ? MIN_PULSE : HOLDOFF;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W    = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLD,
        ST_HOLDOFF
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic [1:0]       cause_q, cause_d;
    logic             key_pend_q, key_pend_d;

    logic            sync1, btn_s;
    logic            btn_db, btn_press;
    logic [DB_W-1:0] db_cnt;
    logic            trigger;

    // The synchroniser runs every cycle so the button is never sampled stale
    always_ff @(posedge clk14) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            btn_s <= 1'b1;
        end else begin
            sync1 <= btn_n;
            btn_s <= sync1;
        end
    end

    always_ff @(posedge clk14) begin
        if (!rst_n) begin
            btn_db    <= 1'b1;
            db_cnt    <= '0;
            btn_press <= 1'b0;
        end else if (enable) begin
            btn_press <= 1'b0;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db    <= btn_s;
                    db_cnt    <= '0;
                    btn_press <= ~btn_s;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign trigger = osd_req | btn_press | key_pend_q;

    always_ff @(posedge clk14) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b1;
            busy_q     <= 1'b0;
            cause_q    <= 2'd0;
            key_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            cause_q    <= cause_d;
            key_pend_q <= key_pend_d;
        end
    end

    // A keyboard pulse arriving mid-request is dropped rather than queued
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        cause_d    = cause_q;
        key_pend_d = key_pend_q;

        if (key_req)
            key_pend_d = (state_q == ST_IDLE);

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d    = ST_ASSERT;
                        cnt_d      = '0;
                        req_d      = 1'b0;
                        key_pend_d = 1'b0;
                        if (osd_req)
                            cause_d = 2'd3;
                        else if (btn_press)
                            cause_d = 2'd2;
                        else
                            cause_d = 2'd1;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q == PULSE_LAST) begin
                        if (osd_req || !btn_db) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_HOLDOFF;
                            req_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!osd_req && btn_db) begin
                        state_d = ST_HOLDOFF;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == HOLD_LAST)
                        state_d = ST_IDLE;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign req_rst_n = req_q;
    assign busy      = busy_q;
    assign cause     = cause_q;

endmodule
